// File: rtl/trace_pkg.sv
// Shared types and constants for the trace capture buffer.
package trace_pkg;

    localparam int unsigned TRACE_XLEN  = 32;
    localparam int unsigned TRACE_DEPTH = 16;
    localparam int unsigned DROP_CNT_W  = 16;

    // One captured retirement record; field order matches the write concatenation.
    typedef struct packed {
        logic [TRACE_XLEN-1:0] instruction;
        logic [TRACE_XLEN-1:0] pc;
        logic [TRACE_XLEN-1:0] result;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module trace_fifo_mem
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = TRACE_DEPTH,
    parameter int unsigned WIDTH = $bits(trace_entry_t),
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the tail entry on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head entry falls through combinationally.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/trace_capture.sv
// Trace capture FIFO: records retired-instruction debug records, first-word
// fall-through output, sticky overflow flag.
// Optional feature: define TRACE_DROP_COUNT_EN to add a saturating 16-bit
// drop_count output.
module trace_capture
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = TRACE_DEPTH,
    parameter int unsigned XLEN  = TRACE_XLEN,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trace_en,
    input  logic                  clear,
    input  logic [XLEN-1:0]       dbg_instruction,
    input  logic [XLEN-1:0]       dbg_pc,
    input  logic [XLEN-1:0]       dbg_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_instruction,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_result,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
`ifdef TRACE_DROP_COUNT_EN
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count
`else
    output logic                  overflow
`endif
);

    localparam int unsigned EW = 3 * XLEN;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          is_full, is_empty;
    logic          push, pop, drop;
    logic [EW-1:0] wr_entry, rd_entry;

    // Occupancy flags and the push/pop/drop decisions for this edge.
    always_comb begin
        is_empty = (count_q == '0);
        is_full  = (count_q == CW'(DEPTH));
        pop      = !clear && !is_empty && out_ready;
        push     = !clear && trace_en && (!is_full || pop);
        drop     = !clear && trace_en && is_full && !pop;
        wr_entry = {dbg_instruction, dbg_pc, dbg_result};
    end

    // Next pointer, occupancy and overflow state; clear overrides everything.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop) count_d = count_q + CW'(1);
            if (pop && !push) count_d = count_q - CW'(1);
            if (drop) overflow_d = 1'b1;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef TRACE_DROP_COUNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of dropped entries.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Expose the drop counter.
    always_comb begin
        drop_count = drop_cnt_q;
    end
`endif

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Drive outputs from state and the fall-through head entry.
    always_comb begin
        out_valid                               = !is_empty;
        {out_instruction, out_pc, out_result}   = rd_entry;
        count                                   = count_q;
        full                                    = is_full;
        empty                                   = is_empty;
        overflow                                = overflow_q;
    end

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter: DEPTH, 16, entry count; power of two, >=2.
REQ-002 Parameter: XLEN, 32, width of the instruction, PC and result fields.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: trace_en  in  1  capture enable, sampled each rising edge.
REQ-006 Port: clear  in  1  synchronous flush.
REQ-007 Port: dbg_instruction  in  XLEN  retired instruction from the processor debug port.
REQ-008 Port: dbg_pc  in  XLEN  PC of the retired instruction.
REQ-009 Port: dbg_result  in  XLEN  writeback result of the retired instruction.
REQ-010 Port: out_valid  out  1  head entry available.
REQ-011 Port: out_ready  in  1  consumer accepts the head entry.
REQ-012 Port: out_instruction / out_pc / out_result  out  XLEN each  head entry fields.
REQ-013 Port: count  out  $clog2(DEPTH)+1  current occupancy.
REQ-014 Port: full, empty  out  1 each  occupancy flags.
REQ-015 Port: overflow  out  1  sticky flag: at least one entry was dropped.

Function
REQ-016 Push: when trace_en=1 at a rising edge, {dbg_instruction, dbg_pc, dbg_result} is written at the tail.
REQ-017 Pop: when out_valid=1 and out_ready=1 at a rising edge, the head entry is removed.
REQ-018 Output is first-word-fall-through: out_valid = !empty; out_* drive the head entry combinationally from storage.
REQ-019 Latency: an entry pushed at edge N drives out_* with out_valid=1 after edge N when the FIFO was empty.
REQ-020 Full + push without pop: entry dropped, FIFO unchanged, overflow set at that edge.
REQ-021 Full + push + pop in the same edge: both are performed; count stays DEPTH; no drop.
REQ-022 Empty + pop: ignored, because out_valid=0.
REQ-023 Simultaneous push and pop when not full: count unchanged and both pointers advance.
REQ-024 Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count distinguishes full from empty.
REQ-025 clear=1 has priority over push and pop: count, pointers and overflow go to 0; the push in that cycle is discarded.
REQ-026 overflow remains 1 until clear or reset.
REQ-027 out_* content is don't-care while out_valid=0; the bench does not check it.
REQ-028 Entry order is strict FIFO, and no entry is duplicated or reordered.

Reset
REQ-029 On reset assertion, immediately and without a clock: count=0, empty=1, full=0, out_valid=0, overflow=0, pointers=0.
REQ-030 Storage contents are not reset.
REQ-031 Reset asserted mid-operation discards all stored entries.
REQ-032 The first push may occur at the first rising edge after reset deassertion.

Configuration
REQ-033 Macro TRACE_DROP_COUNT_EN, when defined, adds output drop_count (16 bits): increments on every dropped entry, saturates at 16'hFFFF, and clears on reset or clear.
REQ-034 Without TRACE_DROP_COUNT_EN, the drop_count port and its counter do not exist; all other behaviour is identical.

Structure
REQ-035 Shared package trace_pkg holds: typedef trace_entry_t (packed instruction, pc, result; 3*XLEN bits), the default DEPTH constant, and the drop counter width constant (16).
REQ-036 Storage is one sub-module, trace_fifo_mem: a DEPTH x trace_entry_t array with one synchronous write port and one asynchronous read port.
REQ-037 Pointer, count and flag logic stays in trace_capture.

Verification
REQ-038 Reset, then trace_en=1 for 3 edges with pc=0x00,0x04,0x08 and out_ready=0 -> count=3, out_pc=0x00, out_valid=1.
REQ-039 Fill with DEPTH=16 entries, push a 17th with pc=0x40 -> full=1, overflow=1, drop_count=1 if enabled, count=16, and entry 0x40 is never output.
REQ-040 Full FIFO, push pc=0x100 with out_ready=1 in the same edge -> count stays 16, overflow stays 0, and 0x100 is the last entry output.
REQ-041 Continuous push and pop for 40 edges with DEPTH=16 -> pointers wrap twice, all 40 PCs are output in order, count stays 1.
REQ-042 count=5 and overflow=1, clear=1 with trace_en=1 for one edge -> count=0, empty=1, overflow=0, and the pushed entry is absent.
REQ-043 Assert reset asynchronously between edges with count=7 -> out_valid=0 and count=0 before the next edge.
